// File: rtl/char_glyph_fetch_if.sv
// Handshake and ROM bus bundle for the character glyph fetcher.
// The master side is the fetcher; the slave side is the controller/ROM/renderer environment.
`timescale 1ns/1ps

interface char_glyph_fetch_if #(
    parameter int CODE_WIDTH = 9,
    parameter int ROW_BITS   = 4,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic [CODE_WIDTH-1:0] req_code;

    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;

    logic                  row_valid;
    logic                  row_ready;
    logic [DATA_WIDTH-1:0] row_data;
    logic [ROW_BITS-1:0]   row_idx;
    logic                  row_last;

    logic                  busy;

    modport master (
        input  req_valid, req_code, rom_data, row_ready,
        output req_ready, rom_addr, row_valid, row_data, row_idx, row_last, busy
    );

    modport slave (
        output req_valid, req_code, rom_data, row_ready,
        input  req_ready, rom_addr, row_valid, row_data, row_idx, row_last, busy
    );
endinterface

// File: rtl/char_glyph_fetch.sv
// Font ROM reader: takes one character code, walks its 16 glyph rows through the ROM
// and streams them to the overlay renderer over valid/ready with credit-based flow control.
`timescale 1ns/1ps

module char_glyph_fetch #(
    parameter int CODE_WIDTH  = 9,
    parameter int ROW_BITS    = 4,
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 16,
    parameter int ROM_LATENCY = 1
) (
    input logic               clk,
    input logic               rst_n,
    char_glyph_fetch_if.master bus
);

    localparam int DEPTH = ROM_LATENCY + 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW = {ROW_BITS{1'b1}};
    localparam logic [PTR_W-1:0]    PTR_MAX  = PTR_W'(DEPTH - 1);

    if (ADDR_WIDTH != CODE_WIDTH + ROW_BITS) begin : g_addr_width_check
        $error("char_glyph_fetch: ADDR_WIDTH must equal CODE_WIDTH + ROW_BITS");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CODE_WIDTH-1:0]  code_q;
    logic [ROW_BITS-1:0]    issue_cnt;
    logic [ROW_BITS-1:0]    out_idx;
    logic [ROM_LATENCY-1:0] issue_pipe;
    logic [ROM_LATENCY:0]   pipe_next;

    logic [DATA_WIDTH-1:0]  fifo_mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       fifo_cnt;
    logic [CNT_W-1:0]       inflight;

    logic req_ready;
    logic busy;
    logic accept;
    logic credit;
    logic issue;
    logic push;
    logic pop;
    logic row_valid;

    // Every word issued to the ROM already owns a FIFO slot, so the FIFO can never overflow.
    assign inflight  = CNT_W'($countones(issue_pipe));
    assign push      = issue_pipe[ROM_LATENCY-1];
    assign row_valid = (fifo_cnt != '0);
    assign pop       = row_valid && bus.row_ready;
    assign credit    = (int'(fifo_cnt) + int'(inflight) - int'(pop)) < DEPTH;
    assign accept    = bus.req_valid && req_ready;
    assign pipe_next = {issue_pipe, issue};

    // NOTE: every combinational output gets a default before the case so no path infers a latch.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (bus.req_valid) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                issue = credit;
                if (credit && (issue_cnt == LAST_ROW)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((inflight == '0) && (fifo_cnt == '0)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The address register shows the row being offered; it only advances once that row is issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q     <= '0;
            issue_cnt  <= '0;
            issue_pipe <= '0;
        end else begin
            issue_pipe <= pipe_next[ROM_LATENCY-1:0];
            if (accept) begin
                code_q    <= bus.req_code;
                issue_cnt <= '0;
            end else if (issue && (issue_cnt != LAST_ROW)) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            out_idx  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
                out_idx <= out_idx + 1'b1;
            end else if (accept) begin
                out_idx <= '0;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; row_data is gated by row_valid so stale words never show.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.rom_data;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.busy      = busy;
    assign bus.rom_addr  = {code_q, issue_cnt};
    assign bus.row_valid = row_valid;
    assign bus.row_data  = row_valid ? fifo_mem[rd_ptr] : '0;
    assign bus.row_idx   = out_idx;
    assign bus.row_last  = row_valid && (out_idx == LAST_ROW);

endmodule
